// File: rtl/onehot_arbiter_pkg.sv
// Shared types and helpers for the registered one-hot arbiter.
// Built into both fixed-priority and ONEHOT_ARBITER_RR_EN round-robin variants.
package onehot_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Widest request vector the index decoder covers.
    localparam int unsigned MAX_REQ = 64;

    function automatic int unsigned onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/onehot_arbiter_pick.sv
// Combinational one-hot winner picker: lowest set bit at or above start (wrapping),
// or the highest set bit when highest is set (start is then ignored).
module onehot_pick #(
    parameter int W     = 8,
    parameter int W_IDX = 3
) (
    input  logic [W-1:0]     vec,
    input  logic             highest,
    input  logic [W_IDX-1:0] start,
    output logic [W-1:0]     pick
);

    logic [2*W-1:0] dbl_in;
    logic [2*W-1:0] dbl_out;
    logic [W-1:0]   rot;
    logic [W-1:0]   rot_pick;
    logic [W-1:0]   rev;
    logic [W-1:0]   rev_pick;
    logic [W-1:0]   up_pick;
    logic [W-1:0]   down_pick;

    always_comb begin
        // Rotate so that bit 'start' lands at position 0, isolate the lowest bit, rotate back.
        dbl_in   = {vec, vec} >> start;
        rot      = dbl_in[W-1:0];
        rot_pick = rot & (~rot + W'(1));
        dbl_out  = {rot_pick, rot_pick} << start;
        up_pick  = dbl_out[2*W-1:W];

        rev = '0;
        for (int i = 0; i < W; i++) rev[i] = vec[W-1-i];
        rev_pick  = rev & (~rev + W'(1));
        down_pick = '0;
        for (int i = 0; i < W; i++) down_pick[i] = rev_pick[W-1-i];

        pick = highest ? down_pick : up_pick;
    end

endmodule

// File: rtl/onehot_arbiter.sv
// Registered one-hot arbiter with grant hold, optional hold timeout (MAX_HOLD)
// and a round-robin mode selected by defining ONEHOT_ARBITER_RR_EN.
module onehot_arbiter
    import onehot_arbiter_pkg::*;
#(
    parameter int W_REQ        = 8,
    parameter int HIGHEST_WINS = 0,
    parameter int MAX_HOLD     = 16,
    parameter int W_IDX        = (W_REQ > 1) ? $clog2(W_REQ) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W_REQ-1:0] req,
    output logic [W_REQ-1:0] gnt,
    output logic             gnt_valid,
    output logic [W_IDX-1:0] gnt_idx
);

    localparam int W_HOLD = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [W_HOLD-1:0] HOLD_LAST = (MAX_HOLD > 0) ? W_HOLD'(MAX_HOLD - 1) : '0;

    arb_state_t        state;
    logic [W_HOLD-1:0] hold_cnt;
    logic [W_REQ-1:0]  others;
    logic [W_REQ-1:0]  pick_req;
    logic [W_REQ-1:0]  pick_oth;
    logic [W_REQ-1:0]  new_gnt;
    logic [W_IDX-1:0]  new_idx;
    logic [W_IDX-1:0]  start;
    logic              highest;
    logic              released;
    logic              timed_out;
    logic              load;

`ifdef ONEHOT_ARBITER_RR_EN
    logic [W_IDX-1:0] rr_ptr;
    logic [W_IDX-1:0] next_ptr;
    assign start    = rr_ptr;
    assign highest  = 1'b0;
    assign next_ptr = (new_idx == W_IDX'(W_REQ - 1)) ? '0 : new_idx + W_IDX'(1);
`else
    assign start   = '0;
    assign highest = (HIGHEST_WINS != 0);
`endif

    onehot_pick #(.W(W_REQ), .W_IDX(W_IDX)) u_pick_req (
        .vec     (req),
        .highest (highest),
        .start   (start),
        .pick    (pick_req)
    );

    onehot_pick #(.W(W_REQ), .W_IDX(W_IDX)) u_pick_oth (
        .vec     (others),
        .highest (highest),
        .start   (start),
        .pick    (pick_oth)
    );

    // The current holder is masked out, so a release and a timeout both hand over the same way.
    assign others    = req & ~gnt;
    assign released  = ~|(req & gnt);
    assign timed_out = (MAX_HOLD > 0) && (hold_cnt == HOLD_LAST);
    assign new_gnt   = (state == IDLE) ? pick_req : pick_oth;
    assign new_idx   = W_IDX'(onehot_to_idx(MAX_REQ'(new_gnt)));
    assign load      = (state == IDLE) ? (|req) : ((released || timed_out) && (|others));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_idx   <= '0;
            hold_cnt  <= '0;
`ifdef ONEHOT_ARBITER_RR_EN
            rr_ptr    <= '0;
`endif
        end else if (load) begin
            state     <= GRANT;
            gnt       <= new_gnt;
            gnt_valid <= 1'b1;
            gnt_idx   <= new_idx;
            hold_cnt  <= '0;
`ifdef ONEHOT_ARBITER_RR_EN
            rr_ptr    <= next_ptr;
`endif
        end else if (state == GRANT && released) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
        end else if (state == GRANT && MAX_HOLD > 0 && hold_cnt != HOLD_LAST) begin
            hold_cnt  <= hold_cnt + W_HOLD'(1);
        end
    end

endmodule

// File: tb/tb_onehot_arbiter.sv
// Scoreboard bench for onehot_arbiter: three 8-requester variants share one request
// vector and a 1-requester variant runs alongside; a reference model queues expectations.
module tb_onehot_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req8;
    logic       req1;

    logic [7:0] gnt_a, gnt_b, gnt_d;
    logic       vld_a, vld_b, vld_d, vld_c;
    logic [2:0] idx_a, idx_b, idx_d;
    logic       gnt_c;
    logic       idx_c;

    onehot_arbiter #(.W_REQ(8), .HIGHEST_WINS(0), .MAX_HOLD(4)) dut_a (
        .clk(clk), .rst(rst), .req(req8), .gnt(gnt_a), .gnt_valid(vld_a), .gnt_idx(idx_a));
    onehot_arbiter #(.W_REQ(8), .HIGHEST_WINS(1), .MAX_HOLD(0)) dut_b (
        .clk(clk), .rst(rst), .req(req8), .gnt(gnt_b), .gnt_valid(vld_b), .gnt_idx(idx_b));
    onehot_arbiter dut_d (
        .clk(clk), .rst(rst), .req(req8), .gnt(gnt_d), .gnt_valid(vld_d), .gnt_idx(idx_d));
    onehot_arbiter #(.W_REQ(1)) dut_c (
        .clk(clk), .rst(rst), .req(req1), .gnt(gnt_c), .gnt_valid(vld_c), .gnt_idx(idx_c));

`ifdef ONEHOT_ARBITER_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif
    localparam int HW [3] = '{0, 1, 0};
    localparam int MH [3] = '{4, 0, 16};

    typedef struct {
        int         inst;
        logic [7:0] g;
        int         idx;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m_g   [3];
    int         m_idx [3];
    int         m_cnt [3];
    int         m_ptr [3];
    int         n_checks = 0;
    int         n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick_idx(input logic [7:0] v, input int hw, input int ptr);
        int i;
        for (int k = 0; k < 8; k++) begin
            i = RR_MODE ? (ptr + k) % 8 : ((hw != 0) ? 7 - k : k);
            if (v[3'(i)]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_g[k] = '0; m_idx[k] = 0; m_cnt[k] = 0; m_ptr[k] = 0;
        end
    endtask

    task automatic model_step(input int k, input logic [7:0] r);
        logic [7:0] oth;
        logic       rel, tmo, ld;
        int         w;
        oth = r & ~m_g[k];
        ld  = 1'b0;
        w   = -1;
        if (m_g[k] == 8'd0) begin
            w  = pick_idx(r, HW[k], m_ptr[k]);
            ld = (w >= 0);
        end else begin
            rel = ((r & m_g[k]) == 8'd0);
            tmo = (MH[k] > 0) && (m_cnt[k] >= MH[k] - 1);
            w   = pick_idx(oth, HW[k], m_ptr[k]);
            ld  = (rel || tmo) && (w >= 0);
            if (!ld && rel) m_g[k] = '0;
            else if (!ld && m_cnt[k] < MH[k] - 1) m_cnt[k]++;
        end
        if (ld) begin
            m_g[k]   = 8'd1 << w;
            m_idx[k] = w;
            m_cnt[k] = 0;
            m_ptr[k] = (w + 1) % 8;
        end
    endtask

    function automatic logic [7:0] obs_g(input int k);
        case (k)
            0:       return gnt_a;
            1:       return gnt_b;
            2:       return gnt_d;
            default: return {7'd0, gnt_c};
        endcase
    endfunction

    function automatic int obs_idx(input int k);
        case (k)
            0:       return 32'(idx_a);
            1:       return 32'(idx_b);
            2:       return 32'(idx_d);
            default: return 32'(idx_c);
        endcase
    endfunction

    function automatic logic obs_vld(input int k);
        case (k)
            0:       return vld_a;
            1:       return vld_b;
            2:       return vld_d;
            default: return vld_c;
        endcase
    endfunction

    // Called on a falling edge; returns on the next falling edge with outputs settled.
    task automatic cyc(input logic [7:0] r, input logic r1);
        exp_t e;
        logic [7:0] g;
        req8 = r;
        req1 = r1;
        for (int k = 0; k < 3; k++) begin
            model_step(k, r);
            sb.push_back('{k, m_g[k], m_idx[k]});
        end
        sb.push_back('{3, {7'd0, r1}, 0});
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            g = obs_g(e.inst);
            check($sformatf("gnt%0d", e.inst), 32'(g), 32'(e.g));
            check($sformatf("idx%0d", e.inst), 32'(obs_idx(e.inst)), 32'(e.idx));
            check($sformatf("vld%0d", e.inst), 32'(obs_vld(e.inst)), 32'(e.g != 8'd0));
            check($sformatf("onehot%0d", e.inst), 32'($onehot0(g)), 32'd1);
            check($sformatf("subset%0d", e.inst), 32'(g & ~((e.inst == 3) ? {7'd0, r1} : r)), 32'd0);
        end
        @(negedge clk);
    endtask

    initial begin
        rst  = 1'b1;
        req8 = '0;
        req1 = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check("rst_gnt", 32'(obs_g(k)), 32'd0);
            check("rst_vld", 32'(obs_vld(k)), 32'd0);
            check("rst_idx", 32'(obs_idx(k)), 32'd0);
        end
        rst = 1'b0;

        cyc(8'b0110_0000, 1'b1);
        cyc(8'b0110_0000, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_a", 32'(gnt_a), 32'd0);
        check("async_rst_b", 32'(gnt_b), 32'd0);
        check("async_rst_c", 32'(gnt_c), 32'd0);
        check("async_rst_vld", 32'(vld_d), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cyc(8'b0110_0000, 1'b0);
`ifndef ONEHOT_ARBITER_RR_EN
        check("rst_low_gnt", 32'(gnt_a), 32'h20);
        check("rst_low_idx", 32'(idx_a), 32'd5);
        check("rst_high_gnt", 32'(gnt_b), 32'h40);
        check("rst_high_idx", 32'(idx_b), 32'd6);
`endif

        cyc(8'b0000_0011, 1'b1);
        check("hold_first", 32'(gnt_a), 32'h01);
        cyc(8'b0000_0010, 1'b0);
        check("b2b_release", 32'(gnt_a), 32'h02);
        cyc(8'b0000_0000, 1'b1);
        check("idle_gnt", 32'(gnt_a), 32'd0);
        check("idle_vld", 32'(vld_a), 32'd0);
        check("idle_idx_held", 32'(idx_a), 32'd1);

        for (int i = 0; i < 12; i++) begin
            cyc(8'b0010_0100, 1'(i % 3 != 0));
            check("tmo_alternate", 32'(idx_a), (((i / 4) % 2) != 0) ? 32'd5 : 32'd2);
        end
        for (int i = 0; i < 24; i++) begin
            cyc(8'b0000_0100, 1'(i % 2));
            check("tmo_sole_hold", 32'(idx_a), 32'd2);
        end

        for (int i = 0; i < 300; i++) begin
            logic [7:0] r;
            r = 8'($urandom);
            if (i % 3 == 0) r = r & 8'($urandom);
            cyc(r, 1'($urandom_range(0, 1)));
        end

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cyc(8'hFF, 1'b1);
        check("fair_first", 32'(idx_a), 32'd0);
        for (int i = 0; i < 8; i++) begin
            cyc(8'hFF & ~m_g[0], 1'b1);
`ifdef ONEHOT_ARBITER_RR_EN
            check("rr_order", 32'(idx_a), 32'((i + 1) % 8));
`endif
        end
        cyc(8'h00, 1'b0);
        cyc(8'b1000_0001, 1'b1);
`ifdef ONEHOT_ARBITER_RR_EN
        check("rr_wrap_7", 32'(idx_a), 32'd7);
`endif
        cyc(8'b0000_0001, 1'b0);
        check("rr_then_0", 32'(idx_a), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
